mpr121_target_model: RTL and testbench

I2C target that responds at a fixed 7-bit address and presents an MPR121-compatible register file to an external I2C initiator. It is the bus-side counterpart of the touch-sensor controller: it lets the controller's full init/verify/poll sequence run in simulation or on-board with no sensor attached, and it reports touch status from a driven `touch_in` vector. It sits between the open-drain SCL/SDA pins and a small register file, all in the `clk_in` domain.

---
 rtl/mpr121_pkg.sv | 27 ++
 rtl/mpr121_target_model_i2c_bus_monitor.sv | 54 +++++
 rtl/mpr121_target_model.sv | 237 +++++++++++++++++++++++
 tb/tb_mpr121_target_model.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpr121_pkg.sv
// Shared constants and state type for the MPR121 target model.
package mpr121_pkg;

    localparam logic [7:0] TOUCH_L       = 8'h00;
    localparam logic [7:0] TOUCH_H       = 8'h01;
    localparam logic [7:0] THRESH_BASE   = 8'h41;
    localparam logic [7:0] THRESH_LAST   = 8'h5A;
    localparam logic [7:0] CONFIG2       = 8'h5D;
    localparam logic [7:0] ECR           = 8'h5E;

    localparam logic [7:0] CONFIG2_RESET = 8'h24;
    localparam int         THRESH_COUNT  = 26;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/mpr121_target_model_i2c_bus_monitor.sv
// Synchronizes SCL/SDA into clk_in and produces single-cycle bus event pulses.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    // Events stay masked until the chains hold real pin samples, so a reset
    // in the middle of a transfer cannot fabricate a START or STOP.
    logic [SYNC_STAGES:0]   armed_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   armed;

    // Synchronizer chains, edge-detect flops and post-reset arming.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            armed_q  <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            armed_q  <= {armed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign armed     = armed_q[SYNC_STAGES];

    assign scl_rise  = armed &  scl_s & ~scl_d;
    assign scl_fall  = armed & ~scl_s &  scl_d;
    assign start_det = armed &  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  = armed &  scl_s &  scl_d & ~sda_d &  sda_s;
    assign sda_level = sda_s;

endmodule

// File: rtl/mpr121_target_model.sv
// I2C target presenting an MPR121-compatible register file.
//
// state      | meaning
// IDLE       | bus free or just reset, waiting for START
// ADDR       | shifting in 7-bit address and R/W
// ADDR_ACK   | driving ACK for our address
// REG        | shifting in register pointer
// REG_ACK    | driving ACK for the pointer byte
// WDATA      | shifting in a write data byte
// WDATA_ACK  | driving ACK for the data byte
// RDATA      | driving the byte at the pointer, MSB first
// RDATA_ACK  | SDA released, sampling initiator ACK/NACK
// IGNORE     | not addressed or NACKed; SDA released until START/STOP
module mpr121_target_model
    import mpr121_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [11:0] touch_in,
    output logic [7:0]  ecr_out,
    output logic        busy_out,
    output logic        wr_valid_out,
    output logic [7:0]  wr_addr_out,
    output logic [7:0]  wr_data_out
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_level;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_level)
    );

    i2c_state_t  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [6:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        rw_q, rw_d;
    logic        wr_en;
    logic        snap_en;

    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;

    logic [7:0]  thresh_q [THRESH_COUNT];
    logic [7:0]  config2_q;
    logic [7:0]  ecr_q;
    logic [11:0] touch_hold_q;
    logic        in_thresh;
    logic [4:0]  thresh_idx;
    logic        wr_ok;

    // Byte as it will look once the bit on SDA right now is shifted in.
    assign rx_byte    = {shift_q, sda_level};

    assign in_thresh  = (ptr_q >= THRESH_BASE) && (ptr_q <= THRESH_LAST);
    assign thresh_idx = 5'(ptr_q - THRESH_BASE);
    assign wr_ok      = in_thresh ? (ecr_q[3:0] == 4'h0)
                                  : ((ptr_q == CONFIG2) || (ptr_q == ECR));

    // Read mux: value of the register at the pointer, fetched when a byte starts.
    always_comb begin
        rd_byte = 8'h00;
        if (in_thresh) begin
            rd_byte = thresh_q[thresh_idx];
        end else begin
            case (ptr_q)
                TOUCH_L: if (ecr_q[3:0] != 4'h0) rd_byte = touch_hold_q[7:0];
                TOUCH_H: if (ecr_q[3:0] != 4'h0) rd_byte = {4'h0, touch_hold_q[11:8]};
                CONFIG2: rd_byte = config2_q;
                ECR:     rd_byte = ecr_q;
                default: rd_byte = 8'h00;
            endcase
        end
    end

    // FSM and bit-level datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 7'd0;
            tx_q      <= 7'd0;
            ptr_q     <= 8'd0;
            oe_q      <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            rw_q      <= rw_d;
        end
    end

    // Next-state logic. In the ACK states oe_q doubles as the phase flag:
    // the first SCL fall starts the ACK, the second one ends it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        rw_d      = rw_q;
        wr_en     = 1'b0;
        snap_en   = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            snap_en   = 1'b1;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_ADDR) begin
                                rw_d    = sda_level;
                                state_d = (rx_byte[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                            end else if (state_q == ST_REG) begin
                                ptr_d   = rx_byte;
                                state_d = ST_REG_ACK;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_d   = ptr_q + 8'd1;
                                state_d = ST_WDATA_ACK;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d   = ST_RDATA;
                            tx_d      = rd_byte[6:0];
                            oe_d      = ~rd_byte[7];
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d   = (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                            oe_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            oe_d = ~tx_q[6];
                            tx_d = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                    end else if (scl_fall) begin
                        if (!shift_q[0]) begin
                            state_d   = ST_RDATA;
                            tx_d      = rd_byte[6:0];
                            oe_d      = ~rd_byte[7];
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_IGNORE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file, touch snapshot and write notification.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < THRESH_COUNT; i++) thresh_q[i] <= 8'h00;
            config2_q    <= CONFIG2_RESET;
            ecr_q        <= 8'h00;
            touch_hold_q <= 12'h000;
            wr_valid_out <= 1'b0;
            wr_addr_out  <= 8'h00;
            wr_data_out  <= 8'h00;
        end else begin
            wr_valid_out <= 1'b0;
            if (snap_en) touch_hold_q <= touch_in;
            if (wr_en && wr_ok) begin
                if (in_thresh)              thresh_q[thresh_idx] <= rx_byte;
                else if (ptr_q == CONFIG2)  config2_q <= rx_byte;
                else                        ecr_q     <= rx_byte;
                wr_valid_out <= 1'b1;
                wr_addr_out  <= ptr_q;
                wr_data_out  <= rx_byte;
            end
        end
    end

    assign sda_oe_out = oe_q;
    assign ecr_out    = ecr_q;
    assign busy_out   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mpr121_target_model.sv
// Bench for mpr121_target_model: bit-banged I2C initiator plus a register-map model.
module tb_mpr121_target_model;

    localparam int         Q      = 6;
    localparam logic [7:0] ADDR_W = 8'hB4;
    localparam logic [7:0] ADDR_R = 8'hB5;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        scl    = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_line;
    logic        sda_oe_out;
    logic [11:0] touch_in = 12'h000;
    logic [7:0]  ecr_out;
    logic        busy_out;
    logic        wr_valid_out;
    logic [7:0]  wr_addr_out;
    logic [7:0]  wr_data_out;

    assign sda_line = sda_drv & ~sda_oe_out;

    mpr121_target_model dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_oe_out   (sda_oe_out),
        .touch_in     (touch_in),
        .ecr_out      (ecr_out),
        .busy_out     (busy_out),
        .wr_valid_out (wr_valid_out),
        .wr_addr_out  (wr_addr_out),
        .wr_data_out  (wr_data_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [256];
    logic [7:0]  m_ptr;
    logic [11:0] m_touch;
    int          exp_wr_cnt = 0;
    logic [7:0]  exp_wr_a, exp_wr_d;

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_mem[8'h5D] = 8'h24;
        m_ptr = 8'h00;
    endtask

    function automatic bit m_writable(input logic [7:0] a);
        if (a >= 8'h41 && a <= 8'h5A) return m_mem[8'h5E][3:0] == 4'h0;
        return (a == 8'h5D) || (a == 8'h5E);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a == 8'h00) return (m_mem[8'h5E][3:0] == 4'h0) ? 8'h00 : m_touch[7:0];
        if (a == 8'h01) return (m_mem[8'h5E][3:0] == 4'h0) ? 8'h00 : {4'h0, m_touch[11:8]};
        return m_mem[a];
    endfunction

    // observed write pulses
    int         wr_cnt = 0;
    logic [7:0] wr_last_a, wr_last_d;

    always @(negedge clk_in) begin
        if (wr_valid_out) begin
            wr_cnt++;
            wr_last_a = wr_addr_out;
            wr_last_d = wr_data_out;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic bus_start();
        m_touch = touch_in;
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wait_clk(Q);
        scl = 1'b1;  wait_clk(2 * Q);
        scl = 1'b0;  wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        b = sda_line;   wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic nack;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nack);
        ack = ~nack;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic [7:0] tmp;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            tmp[i] = b;
        end
        d = tmp;
        send_bit(~ack);
    endtask

    // ---------------- transactions ----------------
    logic [7:0] wq [$];

    task automatic do_write(input logic [7:0] reg_a);
        logic ack;
        bus_start();
        send_byte(ADDR_W, ack); chk("wr addr ack", ack, 1);
        send_byte(reg_a, ack);  chk("wr reg ack", ack, 1);
        m_ptr = reg_a;
        foreach (wq[i]) begin
            send_byte(wq[i], ack);
            chk($sformatf("wr data ack @%02h", m_ptr), ack, 1);
            if (m_writable(m_ptr)) begin
                m_mem[m_ptr] = wq[i];
                exp_wr_cnt++;
                exp_wr_a = m_ptr;
                exp_wr_d = wq[i];
            end
            m_ptr++;
        end
        bus_stop();
        chk("wr pulse count", wr_cnt, exp_wr_cnt);
        if (exp_wr_cnt > 0) begin
            chk("wr_addr_out", wr_last_a, exp_wr_a);
            chk("wr_data_out", wr_last_d, exp_wr_d);
        end
        chk("ecr_out", ecr_out, m_mem[8'h5E]);
        chk("busy after stop", busy_out, 0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] reg_a, input int n, input logic chg);
        logic       ack;
        logic [7:0] d;
        bus_start();
        chk("busy in txn", busy_out, 1);
        if (set_ptr) begin
            send_byte(ADDR_W, ack); chk("rd addrw ack", ack, 1);
            send_byte(reg_a, ack);  chk("rd reg ack", ack, 1);
            m_ptr = reg_a;
            bus_start();
        end
        send_byte(ADDR_R, ack); chk("rd addrr ack", ack, 1);
        if (chg) touch_in = 12'($urandom);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i != n - 1);
            chk($sformatf("rd data @%02h", m_ptr), d, m_read(m_ptr));
            m_ptr++;
        end
        bus_stop();
        chk("oe after read", sda_oe_out, 0);
        chk("busy after read", busy_out, 0);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'(8'h41 + $urandom_range(0, 25));
            3:       return 8'h5D;
            4:       return 8'h5E;
            5:       return 8'(8'h58 + $urandom_range(0, 7));
            6:       return 8'(8'hFD + $urandom_range(0, 2));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] rnd_data();
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 1) == 1) v[3:0] = 4'h0;
        return v;
    endfunction

    initial begin
        logic ack;
        int   n;
        m_reset();
        wait_clk(3);
        rst_in = 1'b0;
        wait_clk(5);

        chk("rst sda_oe", sda_oe_out, 0);
        chk("rst ecr", ecr_out, 8'h00);
        chk("rst busy", busy_out, 0);
        chk("rst wr_valid", wr_valid_out, 0);
        chk("rst wr_addr", wr_addr_out, 8'h00);
        chk("rst wr_data", wr_data_out, 8'h00);

        // ECR write
        wq = '{8'h0C}; do_write(8'h5E);
        chk("ecr 0x0C", ecr_out, 8'h0C);

        // thresholds with ECR cleared, repeated-start readback, pointer carry-over
        wq = '{8'h00}; do_write(8'h5E);
        wq = '{8'h77}; do_write(8'h43);
        wq = '{8'h0F, 8'h0A}; do_write(8'h41);
        do_read(1'b1, 8'h41, 2, 1'b0);
        do_read(1'b0, 8'h00, 1, 1'b0);

        // thresholds locked while running
        wq = '{8'h0C}; do_write(8'h5E);
        wq = '{8'h55}; do_write(8'h42);
        do_read(1'b1, 8'h42, 1, 1'b0);
        do_read(1'b1, 8'h5D, 1, 1'b0);

        // touch snapshot coherence
        touch_in = 12'hA35;
        do_read(1'b1, 8'h00, 2, 1'b1);

        // foreign address ignored until STOP
        bus_start();
        send_byte({7'h3C, 1'b0}, ack); chk("foreign addr nack", ack, 0);
        chk("busy while ignoring", busy_out, 1);
        send_byte(8'h5E, ack); chk("ignored byte1 nack", ack, 0);
        send_byte(8'h00, ack); chk("ignored byte2 nack", ack, 0);
        bus_stop();
        chk("busy after foreign", busy_out, 0);
        chk("ecr after foreign", ecr_out, m_mem[8'h5E]);
        chk("wr count after foreign", wr_cnt, exp_wr_cnt);

        // byte cut short by STOP never writes
        bus_start();
        send_byte(ADDR_W, ack); chk("partial addr ack", ack, 1);
        send_byte(8'h5E, ack);  chk("partial reg ack", ack, 1);
        m_ptr = 8'h5E;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        chk("ecr after partial", ecr_out, m_mem[8'h5E]);
        chk("wr count after partial", wr_cnt, exp_wr_cnt);

        // reset during bit 4 of a read of ECR (0x0C -> bit 4 is a driven 0)
        bus_start();
        send_byte(ADDR_W, ack); chk("rst rd addrw ack", ack, 1);
        send_byte(8'h5E, ack);  chk("rst rd reg ack", ack, 1);
        bus_start();
        send_byte(ADDR_R, ack); chk("rst rd addrr ack", ack, 1);
        for (int i = 0; i < 3; i++) recv_bit(ack);
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        chk("oe before reset", sda_oe_out, 1);
        rst_in = 1'b1;
        #1;
        chk("oe on reset", sda_oe_out, 0);
        chk("ecr on reset", ecr_out, 8'h00);
        chk("busy on reset", busy_out, 0);
        chk("wr_addr on reset", wr_addr_out, 8'h00);
        wait_clk(1);
        rst_in = 1'b0;
        m_reset();
        wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
        bus_stop();
        wq = '{8'h0C}; do_write(8'h5E);
        do_read(1'b1, 8'h5D, 2, 1'b0);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back(rnd_data());
                do_write(pick_addr());
            end else begin
                touch_in = 12'($urandom);
                do_read($urandom_range(0, 3) != 0, pick_addr(), n, $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
